// File: rtl/inst_fetch_responder_pkg.sv
// Shared types for the instruction-fetch responder: FSM state encoding and default widths.
package inst_fetch_responder_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int IFR_STATE_WIDTH = 2;

  typedef enum logic [IFR_STATE_WIDTH-1:0] {
    IFR_IDLE = 2'd0,
    IFR_REQ  = 2'd1,
    IFR_FILL = 2'd2
  } ifr_state_e;

endpackage

// File: rtl/inst_fetch_responder_line_buf.sv
// One-line instruction buffer: LINE_WORDS x DATA_WIDTH registers.
// It has a single write port driven by the refill beat counter and a combinational read port.
module inst_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] words_r [LINE_WORDS];

  // Refill write: one word per accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we) begin
      words_r[waddr] <= wdata;
    end
  end

  assign rdata = words_r[raddr];

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: a single-line buffer in front of a burst-read memory.
// It answers hits in the same cycle and stalls the core while it refills a line on a miss.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
  parameter int DATA_WIDTH = INST_WIDTH,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_en_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o,
  output logic                  pause_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int LOW_BITS = OFF_BITS + 2;
  localparam int TAG_W    = ADDR_WIDTH - LOW_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);
  localparam logic [OFF_BITS-1:0] ONE_BEAT  = OFF_BITS'(1);

  ifr_state_e          state_r, state_s;
  logic                line_valid_r, line_valid_s;
  logic [TAG_W-1:0]    line_tag_r, line_tag_s;
  logic [TAG_W-1:0]    miss_tag_r, miss_tag_s;
  logic [OFF_BITS-1:0] beat_cnt_r, beat_cnt_s;
  logic                drop_r, drop_s;
  logic                we_s;
  logic [TAG_W-1:0]    tag_s;
  logic [OFF_BITS-1:0] word_s;
  logic                hit_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                unused_addr_s;

  assign tag_s         = inst_addr_i[ADDR_WIDTH-1:LOW_BITS];
  assign word_s        = inst_addr_i[LOW_BITS-1:2];
  assign unused_addr_s = ^inst_addr_i[1:0];
  assign hit_s = inst_en_i & line_valid_r & (tag_s == line_tag_r) &
                 (state_r == IFR_IDLE) & ~flush_i;

  inst_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (OFF_BITS)
  ) u_line_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .waddr (beat_cnt_r),
    .wdata (mem_rdata_i),
    .raddr (word_s),
    .rdata (rd_word_s)
  );

  // FSM, line tag/valid, drop flag and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IFR_IDLE;
      line_valid_r <= 1'b0;
      line_tag_r   <= {TAG_W{1'b0}};
      miss_tag_r   <= {TAG_W{1'b0}};
      beat_cnt_r   <= {OFF_BITS{1'b0}};
      drop_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      line_valid_r <= line_valid_s;
      line_tag_r   <= line_tag_s;
      miss_tag_r   <= miss_tag_s;
      beat_cnt_r   <= beat_cnt_s;
      drop_r       <= drop_s;
    end
  end

  // Next-state and output decode. A flush seen while a burst is in flight only marks the line to be dropped.
  always_comb begin
    state_s      = state_r;
    line_valid_s = line_valid_r;
    line_tag_s   = line_tag_r;
    miss_tag_s   = miss_tag_r;
    beat_cnt_s   = beat_cnt_r;
    drop_s       = drop_r;
    we_s         = 1'b0;
    inst_valid_o = hit_s;
    inst_o       = hit_s ? rd_word_s : {DATA_WIDTH{1'b0}};
    pause_o      = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = {ADDR_WIDTH{1'b0}};

    case (state_r)
      IFR_IDLE: begin
        if (flush_i) begin
          line_valid_s = 1'b0;
        end else if (inst_en_i && !hit_s) begin
          state_s    = IFR_REQ;
          miss_tag_s = tag_s;
          pause_o    = rst;
        end else begin
          line_valid_s = line_valid_r;
        end
      end
      IFR_REQ: begin
        pause_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_r, {LOW_BITS{1'b0}}};
        if (flush_i) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
        if (mem_ready_i) begin
          state_s    = IFR_FILL;
          beat_cnt_s = {OFF_BITS{1'b0}};
        end else begin
          state_s = IFR_REQ;
        end
      end
      IFR_FILL: begin
        pause_o = 1'b1;
        if (flush_i) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
        if (mem_rvalid_i) begin
          we_s       = 1'b1;
          beat_cnt_s = beat_cnt_r + ONE_BEAT;
          if (beat_cnt_r == LAST_BEAT) begin
            line_tag_s   = miss_tag_r;
            line_valid_s = ~(drop_r | flush_i);
            drop_s       = 1'b0;
            state_s      = IFR_IDLE;
          end else begin
            state_s = IFR_FILL;
          end
        end else begin
          state_s = IFR_FILL;
        end
      end
      default: begin
        state_s = IFR_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Randomized scoreboard bench for inst_fetch_responder with a burst-memory responder model.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_en_i = 1'b0;
  logic [31:0] inst_addr_i = 32'h0;
  logic        flush_main = 1'b0;
  logic        flush_fill = 1'b0;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        pause_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  assign flush_i = flush_main | flush_fill;

  inst_fetch_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_en_i    (inst_en_i),
    .inst_addr_i  (inst_addr_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .pause_o      (pause_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_req_q[$];
  logic [31:0] mem_img [logic [31:0]];

  int ready_wait = 0;
  int gaps[4] = '{0, 0, 0, 0};
  int flush_at_beat = -1;
  int fetch_id = 0;
  int beat_num = -1;

  bit          model_valid = 1'b0;
  logic [27:0] model_line = 28'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every presented instruction is matched against the scoreboard.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (inst_valid_o) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_valid: got inst_o 0x%08h, expected no response", inst_o);
          end else begin
            w = exp_q.pop_front();
            chk("inst_o", inst_o, w);
            chk("pause_on_hit", {31'b0, pause_o}, 32'h0);
          end
        end else if (!inst_en_i) begin
          chk("idle_inst_o", inst_o, 32'h0);
          chk("idle_flags", {29'b0, inst_valid_o, pause_o, mem_req_o}, 32'h0);
        end
      end
    end
  end

  // Burst memory: accepts a request after ready_wait cycles and returns four beats with gaps.
  initial begin
    logic [31:0] a;
    bit use_flush;
    int last_flush_id;
    last_flush_id = -1;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && mem_req_o) begin
        a = mem_addr_o;
        if (exp_req_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_req: got mem_addr_o 0x%08h, expected no request", a);
        end else begin
          chk("mem_addr_o", a, exp_req_q.pop_front());
        end
        use_flush = (flush_at_beat >= 0) && (fetch_id != last_flush_id);
        if (use_flush) last_flush_id = fetch_id;
        for (int i = 0; i < ready_wait; i++) begin
          @(negedge clk);
          chk("req_hold", {31'b0, mem_req_o}, 32'h1);
          chk("addr_hold", mem_addr_o, a);
          chk("pause_req", {31'b0, pause_o}, 32'h1);
        end
        mem_ready_i = 1'b1;
        @(negedge clk);
        mem_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
          for (int g = 0; g < gaps[b]; g++) begin
            if (rst) chk("pause_fill", {30'b0, pause_o, inst_valid_o}, 32'h2);
            @(negedge clk);
          end
          if (!rst) break;
          flush_fill   = use_flush && (b == flush_at_beat);
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_rd(a + 32'(b * 4));
          beat_num     = b;
          @(negedge clk);
          mem_rvalid_i = 1'b0;
          flush_fill   = 1'b0;
        end
        beat_num    = -1;
        mem_rdata_i = 32'h0;
      end
    end
  end

  // One fetch held until answered; the model predicts hit/miss, request count and latency.
  task automatic fetch(input logic [31:0] a);
    bit hit;
    int nb, lat, cycles;
    @(posedge clk); #1;
    fetch_id++;
    inst_en_i   = 1'b1;
    inst_addr_i = a;
    hit = model_valid && (a[31:4] == model_line);
    exp_q.push_back(mem_rd({a[31:2], 2'b00}));
    nb = 0;
    if (!hit) begin
      nb = (flush_at_beat >= 0) ? 2 : 1;
      for (int i = 0; i < nb; i++) exp_req_q.push_back({a[31:4], 4'h0});
      model_line  = a[31:4];
      model_valid = 1'b1;
    end
    lat = nb * (6 + ready_wait + gaps[0] + gaps[1] + gaps[2] + gaps[3]);
    @(negedge clk);
    chk("first_pause", {31'b0, pause_o}, hit ? 32'h0 : 32'h1);
    if (hit) chk("hit_no_req", {31'b0, mem_req_o}, 32'h0);
    cycles = 0;
    while (!inst_valid_o && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    if (!inst_valid_o) begin
      n_vec++; n_err++;
      $display("FAIL fetch_timeout: addr 0x%08h got no valid in %0d cycles, expected %0d", a, cycles, lat);
    end else begin
      chk("latency", 32'(cycles), 32'(lat));
    end
  endtask

  task automatic idle_flush(input logic [31:0] a);
    @(posedge clk); #1;
    inst_en_i = 1'b1; inst_addr_i = a; flush_main = 1'b1;
    @(negedge clk);
    chk("flush_no_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("flush_no_pause", {31'b0, pause_o}, 32'h0);
    @(posedge clk); #1;
    flush_main = 1'b0; inst_en_i = 1'b0;
    @(negedge clk);
    chk("flush_no_req", {31'b0, mem_req_o}, 32'h0);
    model_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    logic [31:0] a;
    mem_img[32'h1c00_0000] = 32'h0000_00A0;
    mem_img[32'h1c00_0004] = 32'h0000_00A1;
    mem_img[32'h1c00_0008] = 32'h0000_00A2;
    mem_img[32'h1c00_000c] = 32'h0000_00A3;

    #12;
    chk("reset_inst_o", inst_o, 32'h0);
    chk("reset_flags", {29'b0, inst_valid_o, pause_o, mem_req_o}, 32'h0);
    chk("reset_mem_addr", mem_addr_o, 32'h0);
    @(posedge clk); #1; rst = 1'b1;

    // Cold miss, then same-line hits.
    fetch(32'h1c00_0000);
    fetch(32'h1c00_0004);
    fetch(32'h1c00_0008);
    fetch(32'h1c00_000c);

    // Memory holds off the request for three cycles.
    ready_wait = 3;
    fetch(32'h1c00_0010);
    ready_wait = 0;

    // Flush during beat 2 drops the line; the held fetch re-misses.
    flush_at_beat = 2;
    fetch(32'h1c00_0020);
    flush_at_beat = -1;
    fetch(32'h1c00_0024);

    // Gapped beats on cycles 0,2,5,6.
    gaps = '{0, 1, 2, 0};
    fetch(32'h1c00_0030);
    gaps = '{0, 0, 0, 0};
    fetch(32'h1c00_0034);
    fetch(32'h1c00_0038);
    fetch(32'h1c00_003c);

    idle_flush(32'h1c00_0038);
    fetch(32'h1c00_0038);

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    fetch_id++;
    inst_en_i = 1'b1; inst_addr_i = 32'h1c00_0040;
    exp_req_q.push_back(32'h1c00_0040);
    cycles = 0;
    do begin
      @(negedge clk); #2;
      cycles++;
    end while (!(mem_rvalid_i && beat_num == 1) && cycles < 50);
    if (cycles >= 50) begin
      n_vec++; n_err++;
      $display("FAIL beat1_timeout: got no beat 1 in %0d cycles, expected one", cycles);
    end
    rst = 1'b0;
    #1;
    chk("midrst_inst_o", inst_o, 32'h0);
    chk("midrst_flags", {29'b0, inst_valid_o, pause_o, mem_req_o}, 32'h0);
    chk("midrst_mem_addr", mem_addr_o, 32'h0);
    inst_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    model_valid = 1'b0;
    fetch(32'h1c00_0034);

    // Randomized traffic over three lines.
    for (int k = 0; k < 80; k++) begin
      ready_wait = $urandom_range(0, 3);
      for (int b = 0; b < 4; b++) gaps[b] = $urandom_range(0, 2);
      flush_at_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      a = 32'h1c00_0000 + 32'($urandom_range(0, 2)) * 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
      if ($urandom_range(0, 9) == 0) idle_flush(a);
      fetch(a);
      flush_at_beat = -1;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        inst_en_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end

    @(posedge clk); #1; inst_en_i = 1'b0;
    repeat (3) @(posedge clk);
    chk("resp_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("req_queue_empty", 32'(exp_req_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
